axis_capture_buffer: RTL and testbench
======================================

Name: axis_capture_buffer

Overview:
- Capture buffer: records a burst from a realtime (no-backpressure) Axis_If stream into on-chip RAM, then plays it back as a packetized Axis_If stream with `ready`/`valid` handshaking and `last` on the final sample.
- Sits between realtime sample sources (ADC/DDS paths) and the DMA/readout side. It is the receiving end of a realtime stream and the sending end of a packetized stream.

Parameters:
- DWIDTH, 32, sample width in bits.
- DEPTH, 1024, buffer capacity in samples; power of two, >= 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- data_in  Axis_If.Slave_Realtime  DWIDTH  realtime sample input (`valid`, `data`).
- data_out  Axis_If.Master_Full  DWIDTH  packetized output (`ready`, `valid`, `data`, `last`).
- start  input  1  single-cycle capture request.
- capture_len  input  $clog2(DEPTH)+1  number of samples to capture; sampled when `start` is accepted.
- capturing  output  1  high while in CAPTURE.
- readout_active  output  1  high while in READOUT.
- done  output  1  one-cycle pulse when the final output sample transfers.

Behaviour:
- Single clock domain. All state is cleared by synchronous reset.
- Reset values: `data_out.valid`=0, `data_out.last`=0, `data_out.data`=0, `capturing`=0, `readout_active`=0, `done`=0, FSM=IDLE, write/read counters=0.
- FSM states: IDLE, CAPTURE, READOUT.
- IDLE:
  - `start`=1 latches `len` = min(`capture_len`, DEPTH).
  - If `len`=0: stay in IDLE and pulse `done` next cycle.
  - Otherwise: go to CAPTURE, write address = 0.
  - `data_in` is ignored in IDLE.
- CAPTURE:
  - Each cycle with `data_in.valid`=1, write `data_in.data` at the write address and increment it.
  - Cycles with `valid`=0 write nothing.
  - When the write for sample index len-1 occurs, transition to READOUT on the next cycle.
  - Samples arriving after that write are discarded.
  - No sample is ever dropped within the first `len` valid cycles.
- READOUT:
  - Output is driven from RAM through a one-entry registered output stage; RAM read latency is 1 cycle.
  - `data_out.valid` rises no later than 2 cycles after entering READOUT.
  - Samples are emitted in capture order, index 0..len-1, with no gaps while `ready`=1. Once the pipeline is primed, throughput is 1 sample/cycle.
  - While `valid`=1 and `ready`=0, `data` and `last` hold stable; no sample is lost or duplicated.
  - `last`=1 exactly with sample len-1.
  - On `ok`&&`last`: next cycle `valid`=0, `last`=0, `done`=1 for one cycle, FSM returns to IDLE.
- `start` is ignored in CAPTURE and READOUT.
- `capture_len` is only sampled in IDLE.
- `len`=1: a single output beat with `last`=1.
- `len`=DEPTH: the write address wraps to 0 only after the final write. Counter width must hold DEPTH without overflow.
- `capturing` = (FSM==CAPTURE); `readout_active` = (FSM==READOUT); both registered.
- Reset mid-CAPTURE or mid-READOUT: next cycle FSM=IDLE, `valid`=0, buffer contents are don't-care, and no `done` pulse.
- `start` asserted in the same cycle as a final `ok`&&`last`: ignored (FSM not yet IDLE).

Decomposition:
- Shared package: FSM state enum (`IDLE`, `CAPTURE`, `READOUT`) and an address-width helper constant function.
- Sub-module `sdp_ram`: simple dual-port RAM, parameters DWIDTH and DEPTH; one write port, one read port with 1-cycle registered read. Reusable elsewhere.
- Top level holds the FSM, counters and output skid/hold register.

Test Plan:
- `capture_len`=16, `start`, 16 consecutive valid inputs 0..15, `ready` held 1 -> outputs 0..15 in order, `last` only on 15, `done` pulses once, FSM IDLE afterwards.
- `capture_len`=64, input `valid` randomly toggled, `ready` randomly toggled -> exactly 64 outputs matching the valid-input sequence, `last` on the 64th, no duplicates or drops.
- `capture_len`=2000 with DEPTH=1024 -> exactly 1024 samples captured and read out, `last` on the 1024th; extra inputs discarded.
- `capture_len`=1 -> one beat with `last`=1. `capture_len`=0 -> no output `valid`, `done` pulses one cycle after `start`.
- `ready`=0 for 50 cycles mid-readout at sample 7 -> `data`=7 held stable with `valid`=1 throughout; resumes with 8.
- `reset` asserted at output sample 5 of 32 -> next cycle `valid`=0 and FSM IDLE; a new `start` with `capture_len`=4 completes correctly; `start` pulses during CAPTURE are ignored.

Source files
------------

// File: rtl/axis_capture_buffer_pkg.sv
// Shared types and helpers for the capture buffer: FSM state encoding and
// address-width derivation used by the top level and its RAM.
package axis_capture_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        READOUT = 2'd2
    } cap_state_e;

    function automatic int addr_width(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/axis_capture_buffer_if.sv
// Streaming bus bundle: realtime flavour (valid/data only) and full
// packetized flavour (ready/valid/data/last).
interface Axis_If #(
    parameter int DWIDTH = 32
);
    logic              ready;
    logic              valid;
    logic              last;
    logic [DWIDTH-1:0] data;

    modport Master_Full     (input ready, output valid, output data, output last);
    modport Slave_Full      (output ready, input valid, input data, input last);
    modport Master_Realtime (output valid, output data);
    modport Slave_Realtime  (input valid, input data);
endinterface

// File: rtl/axis_capture_buffer_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered
// (1-cycle) read. Read-during-write to the same address returns old data.
module sdp_ram
    import axis_capture_buffer_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 1024
) (
    input  logic                         clk,
    input  logic                         we_i,
    input  logic [addr_width(DEPTH)-1:0] waddr_i,
    input  logic [DWIDTH-1:0]            wdata_i,
    input  logic [addr_width(DEPTH)-1:0] raddr_i,
    output logic [DWIDTH-1:0]            rdata_o
);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [DWIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axis_capture_buffer.sv
// Captures a burst from a realtime stream into RAM, then replays it as a
// packetized stream with ready/valid handshake and last on the final sample.
//
// state   | meaning
// IDLE    | waiting for start; realtime input ignored
// CAPTURE | writing each valid input sample until len samples stored
// READOUT | replaying samples 0..len-1 through the output hold register
module axis_capture_buffer
    import axis_capture_buffer_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    Axis_If.Slave_Realtime           data_in,
    Axis_If.Master_Full              data_out,
    input  logic                     start,
    input  logic [$clog2(DEPTH):0]   capture_len,
    output logic                     capturing,
    output logic                     readout_active,
    output logic                     done
);

    localparam int AW = addr_width(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_CAPTURE = CAPTURE;
    localparam logic [1:0] ST_READOUT = READOUT;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     len_q, len_d;
    logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]     rd_idx_q, rd_idx_d;
    logic              primed_q;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic [DWIDTH-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              capturing_q;
    logic              readout_q;

    logic              ram_we;
    logic [DWIDTH-1:0] ram_rdata;
    logic [CW-1:0]     len_clip;
    logic              out_ok;

    assign len_clip = (capture_len > DEPTH_C) ? DEPTH_C : capture_len;
    assign out_ok   = valid_q && data_out.ready;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        wr_cnt_d = wr_cnt_q;
        rd_idx_d = rd_idx_q;
        valid_d  = valid_q;
        last_d   = last_q;
        data_d   = data_q;
        done_d   = 1'b0;
        ram_we   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d    = len_clip;
                    wr_cnt_d = '0;
                    rd_idx_d = '0;
                    if (len_clip == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                if (data_in.valid) begin
                    ram_we   = 1'b1;
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    if (wr_cnt_q == len_q - 1'b1) begin
                        state_d = ST_READOUT;
                    end
                end
            end
            ST_READOUT: begin
                // RAM output always reflects rd_idx_q once primed, so the hold
                // register can reload every cycle the consumer accepts.
                if (out_ok && last_q) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                end else if ((!valid_q || out_ok) && primed_q && (rd_idx_q < len_q)) begin
                    valid_d  = 1'b1;
                    data_d   = ram_rdata;
                    last_d   = (rd_idx_q == len_q - 1'b1);
                    rd_idx_d = rd_idx_q + 1'b1;
                end else if (out_ok) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            wr_cnt_q    <= '0;
            rd_idx_q    <= '0;
            primed_q    <= 1'b0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            data_q      <= '0;
            done_q      <= 1'b0;
            capturing_q <= 1'b0;
            readout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_idx_q    <= rd_idx_d;
            primed_q    <= (state_q == ST_READOUT);
            valid_q     <= valid_d;
            last_q      <= last_d;
            data_q      <= data_d;
            done_q      <= done_d;
            capturing_q <= (state_d == ST_CAPTURE);
            readout_q   <= (state_d == ST_READOUT);
        end
    end

    // Read address follows the next index so the registered read lands in step.
    sdp_ram #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (wr_cnt_q[AW-1:0]),
        .wdata_i (data_in.data),
        .raddr_i (rd_idx_d[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    assign data_out.valid = valid_q;
    assign data_out.last  = last_q;
    assign data_out.data  = data_q;
    assign capturing      = capturing_q;
    assign readout_active = readout_q;
    assign done           = done_q;

endmodule

// File: tb/tb_axis_capture_buffer.sv
// Directed bench for axis_capture_buffer: capture/readout bursts, clipping,
// zero/one length, stalls, reset mid-readout and ignored start pulses.
module tb_axis_capture_buffer;

    localparam int DW = 32;
    localparam int DP = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] capture_len;
    logic        capturing;
    logic        readout_active;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [31:0] expq [$];

    Axis_If #(.DWIDTH(DW)) in_if ();
    Axis_If #(.DWIDTH(DW)) out_if ();

    axis_capture_buffer #(
        .DWIDTH (DW),
        .DEPTH  (DP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .data_in        (in_if),
        .data_out       (out_if),
        .start          (start),
        .capture_len    (capture_len),
        .capturing      (capturing),
        .readout_active (readout_active),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One capture + readout burst. rmode: 0 ready=1, 1 random, 2 stall 50 cycles at sample 7.
    task automatic run(input int req_len, input int exp_n, input logic [31:0] base,
                       input int vmode, input int rmode, input int abort_at,
                       input int extra, input bit spur);
        int sent, idx, cyc, first_v, stall;
        bit v, r, hold_chk;
        logic [31:0] held;
        expq.delete();
        @(negedge clk);
        capture_len = 11'(req_len);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("cap_enter", {31'd0, capturing}, 32'd1);

        sent = 0;
        cyc = 0;
        while (sent < exp_n && cyc < 5000) begin
            v = (vmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            in_if.valid = v;
            in_if.data = base + 32'(sent);
            if (v) begin
                expq.push_back(base + 32'(sent));
                sent++;
            end
            start = spur && (cyc % 3 == 1);
            capture_len = 11'd3;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        in_if.valid = 1'b0;
        if (sent < exp_n) chk("cap_timeout", 32'(sent), 32'(exp_n));
        chk("cap_exit", {31'd0, capturing}, 32'd0);
        chk("ro_enter", {31'd0, readout_active}, 32'd1);

        idx = 0;
        cyc = 0;
        first_v = -1;
        stall = 0;
        hold_chk = 1'b0;
        held = '0;
        while (idx < exp_n && cyc < 20000) begin
            in_if.valid = (cyc < extra);
            in_if.data = 32'hDEAD_0000 + 32'(cyc);
            if (out_if.valid && first_v < 0) first_v = cyc;
            if (hold_chk) begin
                chk("hold_valid", {31'd0, out_if.valid}, 32'd1);
                chk("hold_data", out_if.data, held);
            end
            if (abort_at == idx && out_if.valid) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                in_if.valid = 1'b0;
                chk("abort_valid", {31'd0, out_if.valid}, 32'd0);
                chk("abort_ro", {31'd0, readout_active}, 32'd0);
                chk("abort_cap", {31'd0, capturing}, 32'd0);
                chk("abort_done", {31'd0, done}, 32'd0);
                return;
            end
            if (rmode == 0) begin
                r = 1'b1;
            end else if (rmode == 1) begin
                r = 1'($urandom_range(0, 1));
            end else if (idx == 7 && out_if.valid && stall < 50) begin
                r = 1'b0;
                stall++;
            end else begin
                r = 1'b1;
            end
            out_if.ready = r;
            hold_chk = out_if.valid && !r;
            held = out_if.data;
            if (out_if.valid && r) begin
                chk("data", out_if.data, expq[idx]);
                chk("last", {31'd0, out_if.last}, {31'd0, (idx == exp_n - 1)});
                if (idx == exp_n - 1) begin
                    start = 1'b1;
                    capture_len = 11'd5;
                end
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        in_if.valid = 1'b0;
        out_if.ready = 1'b1;
        if (idx < exp_n) chk("ro_timeout", 32'(idx), 32'(exp_n));
        if (rmode == 2) chk("stall_len", 32'(stall), 32'd50);
        chk("valid_latency", {31'd0, (first_v >= 0 && first_v <= 2)}, 32'd1);
        chk("end_valid", {31'd0, out_if.valid}, 32'd0);
        chk("end_last", {31'd0, out_if.last}, 32'd0);
        chk("end_done", {31'd0, done}, 32'd1);
        chk("end_ro", {31'd0, readout_active}, 32'd0);
        chk("end_cap", {31'd0, capturing}, 32'd0);
        @(negedge clk);
        chk("done_pulse", {31'd0, done}, 32'd0);
        chk("idle_cap", {31'd0, capturing}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        capture_len = '0;
        in_if.valid = 1'b0;
        in_if.data = '0;
        out_if.ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, out_if.valid}, 32'd0);
        chk("rst_last", {31'd0, out_if.last}, 32'd0);
        chk("rst_data", out_if.data, 32'd0);
        chk("rst_cap", {31'd0, capturing}, 32'd0);
        chk("rst_ro", {31'd0, readout_active}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run(16, 16, 32'd0, 0, 0, -1, 0, 1'b0);
        run(64, 64, 32'h0001_0000, 1, 1, -1, 0, 1'b0);
        run(2000, 1024, 32'h0002_0000, 0, 0, -1, 6, 1'b0);
        run(1, 1, 32'h0003_0000, 0, 0, -1, 2, 1'b0);

        @(negedge clk);
        capture_len = 11'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("len0_done", {31'd0, done}, 32'd1);
        chk("len0_cap", {31'd0, capturing}, 32'd0);
        chk("len0_valid", {31'd0, out_if.valid}, 32'd0);
        @(negedge clk);
        chk("len0_done_end", {31'd0, done}, 32'd0);
        chk("len0_valid_end", {31'd0, out_if.valid}, 32'd0);

        run(16, 16, 32'd0, 0, 2, -1, 0, 1'b0);
        run(32, 32, 32'h0004_0000, 0, 0, 5, 0, 1'b0);
        run(4, 4, 32'h0005_0000, 1, 0, -1, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
